rgb_pwm_ctrl: RTL
=================

# rgb_pwm_ctrl

Parametrised RGB LED controller for the Arty board family. It drives NUM_LEDS tri-colour LEDs with a shared gamma-corrected PWM brightness. Each channel has a short-press colour-cycle FSM and a long-press mode toggle between static and breathing. It sits behind the debounce block and drives the RGB and mono LED pins directly.

## Interface
- NUM_LEDS, 4: number of RGB channels, 1..8.
- PWM_BITS, 8: PWM counter width, 4..12; one PWM period is 2^PWM_BITS cycles.
- LONG_CYCLES, 50_000_000: number of consecutive held cycles that counts as a long press, >= 2.
- BREATHE_DIV, 4: number of PWM periods per breathe-level step, >= 1.
- sclk  in  1  system clock, single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- sw  in  4  brightness select, 0..15; static, sampled every cycle.
- btn  in  NUM_LEDS  debounced, sclk-synchronous buttons, active-high.
- led_r, led_g, led_b  out  NUM_LEDS each  RGB drive, registered.
- led  out  NUM_LEDS  mode indicator (1 = breathe), registered.

## Operation
- PWM counter pwm_cnt:
  - Free-running, PWM_BITS wide, +1 every cycle, wraps from max to 0.
  - period_end = (pwm_cnt == 2^PWM_BITS-1).
- Gamma table: level(sw) for sw 0..15 = 0,1,1,1,1,2,2,3,3,4,5,6,8,10,12,16 (5-bit).
- Base duty = level << (PWM_BITS-4), PWM_BITS+1 bits wide.
  - sw=0 gives always off.
  - sw=15 gives duty = 2^PWM_BITS, i.e. always on.
- Breathe generator, shared by all channels:
  - breathe_lvl is PWM_BITS wide; direction is dir.
  - The prescaler counts period_end events. On BREATHE_DIV events it steps breathe_lvl by ±1.
  - dir flips to down on reaching 2^PWM_BITS-1 and to up on reaching 0. The extremes are held for exactly one step and never overshoot.
- Effective duty for channel i:
  - Static mode: base duty.
  - Breathe mode: (duty × breathe_lvl) >> PWM_BITS, full-width product, truncated.
- Per-channel colour state: 3-bit, sequence RED(0) → GREEN(1) → BLUE(2) → PURPLE(3) → YELLOW(4) → CYAN(5) → RED.
  - RGB bits are 100, 010, 001, 101, 110, 011.
  - Encodings 6 and 7 are unreachable and map to RED / next GREEN.
- Per-channel button FSM; hold_cnt saturates at LONG_CYCLES.
  - IDLE: on btn=1, go to PRESSED with hold_cnt=1.
  - PRESSED:
    - btn=1 and hold_cnt+1 == LONG_CYCLES: toggle mode, go to LONG.
    - btn=1 otherwise: hold_cnt+1.
    - btn=0: advance colour, go to IDLE.
  - LONG: on btn=0, go to IDLE with no colour change. Holding longer has no further effect.
- Output, per cycle: on = (pwm_cnt < effective duty).
  - led_r/g/b[i] <= on & (colour bit | btn[i]). Press preview shows white at the current duty.
  - led[i] <= mode[i].
- Channels are fully independent. Simultaneous presses on different channels are each honoured in the same cycle.

## Timing
- Reset, asynchronous, while resetn=0. State values:
  - pwm_cnt=0, breathe_lvl=0, dir=up, prescaler=0.
  - All colour states RED, all modes static, all FSMs IDLE, hold_cnt=0.
- Reset, output values: led_r/g/b=0 and led=0 during reset and on the first post-reset edge.
- Output latency: 1 cycle. Outputs at edge t+1 reflect pwm_cnt, sw, btn, colour and mode sampled at edge t.
- Colour change timing: btn sampled 0 in PRESSED at edge k updates colour at edge k. The new colour is visible on outputs at edge k+1.
- Mode toggle timing: on the edge where the LONG_CYCLES-th consecutive high sample is seen. led[i] changes 1 cycle later.
- Press of exactly 1 cycle is a valid short press.
- Button held through reset: after resetn deasserts, the FSM is IDLE. A still-high btn starts a new press, and no colour advance occurs from the pre-reset press.
- sw changes take effect on the next compare with no period alignment. Glitch-free duty is not required.

## Test plan
Default setup for all tests: NUM_LEDS=4, PWM_BITS=4, LONG_CYCLES=8, BREATHE_DIV=1.
- Reset release with sw=15 → led_r=4'b1111 continuously from the second edge; led_g=led_b=0; led=0.
- sw=9 (level 4, duty 4) → each led_r[i] is high for exactly 4 of every 16 cycles, aligned to pwm_cnt 0..3 plus 1-cycle latency.
- btn[0] high for 3 cycles, then low, with sw=15 → led_r/g/b[0] all high during the press. Then led_g[0]=1 and led_r[0]=0; channels 1..3 are unchanged.
- Six short presses on btn[2] → colours step through 1,2,3,4,5 and return to RED. A 1-cycle press also advances.
- Hold btn[1] for 10 cycles with sw=15 → led[1] rises 1 cycle after the 8th high sample, with no colour change on release.
  - Afterwards, per-period high time on led_r[1] equals breathe_lvl, ramping 0..15..0.
- Assert resetn=0 mid-hold on btn[3] at cycle 5, release reset with btn still high for 2 cycles → no mode toggle.
  - Colour advances exactly once, on the post-reset release.
  - All outputs are 0 while in reset.

Source files
------------

// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel RGB LED controller: gamma-corrected shared PWM brightness, per-channel
// short-press colour cycling and long-press static/breathe mode toggle.
module rgb_pwm_ctrl #(
    parameter int NUM_LEDS    = 4,
    parameter int PWM_BITS    = 8,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int BREATHE_DIV = 4
) (
    input  logic                  sclk,
    input  logic                  resetn,
    input  logic [3:0]            sw,
    input  logic [NUM_LEDS-1:0]   btn,
    output logic [NUM_LEDS-1:0]   led_r,
    output logic [NUM_LEDS-1:0]   led_g,
    output logic [NUM_LEDS-1:0]   led_b,
    output logic [NUM_LEDS-1:0]   led,
    output logic [2*NUM_LEDS-1:0] fsm_state
);

    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int PRE_W  = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;

    localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;
    localparam logic [PWM_BITS-1:0] LVL_TOP_M1 = CNT_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] LVL_ONE    = PWM_BITS'(1);
    localparam logic [HOLD_W-1:0]   HOLD_LONG  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0]   HOLD_ONE   = HOLD_W'(1);
    localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(BREATHE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } btn_fsm_e;

    function automatic logic [4:0] gamma_level(input logic [3:0] s);
        logic [4:0] lv;
        case (s)
            4'd0:                      lv = 5'd0;
            4'd1, 4'd2, 4'd3, 4'd4:    lv = 5'd1;
            4'd5, 4'd6:                lv = 5'd2;
            4'd7, 4'd8:                lv = 5'd3;
            4'd9:                      lv = 5'd4;
            4'd10:                     lv = 5'd5;
            4'd11:                     lv = 5'd6;
            4'd12:                     lv = 5'd8;
            4'd13:                     lv = 5'd10;
            4'd14:                     lv = 5'd12;
            default:                   lv = 5'd16;
        endcase
        return lv;
    endfunction

    // Returned as {r, g, b}; the unreachable codes fall back to red.
    function automatic logic [2:0] colour_rgb(input logic [2:0] c);
        logic [2:0] rgb;
        case (c)
            3'd0:    rgb = 3'b100;
            3'd1:    rgb = 3'b010;
            3'd2:    rgb = 3'b001;
            3'd3:    rgb = 3'b101;
            3'd4:    rgb = 3'b110;
            3'd5:    rgb = 3'b011;
            default: rgb = 3'b100;
        endcase
        return rgb;
    endfunction

    function automatic logic [2:0] colour_next(input logic [2:0] c);
        logic [2:0] nxt;
        case (c)
            3'd0:    nxt = 3'd1;
            3'd1:    nxt = 3'd2;
            3'd2:    nxt = 3'd3;
            3'd3:    nxt = 3'd4;
            3'd4:    nxt = 3'd5;
            3'd5:    nxt = 3'd0;
            default: nxt = 3'd1;
        endcase
        return nxt;
    endfunction

    // ---------------- PWM counter and breathe generator ----------------
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] breathe_lvl, lvl_d;
    logic                dir_down, dir_d;
    logic [PRE_W-1:0]    presc, presc_d;
    logic                period_end;

    assign period_end = (pwm_cnt == CNT_MAX);

    always_comb begin
        lvl_d   = breathe_lvl;
        dir_d   = dir_down;
        presc_d = presc;
        if (period_end) begin
            if (presc == PRE_LAST) begin
                presc_d = '0;
                // Direction flips on the step that lands on an extreme, so each
                // extreme is shown for exactly one step interval.
                if (dir_down) begin
                    lvl_d = breathe_lvl - 1'b1;
                    if (breathe_lvl == LVL_ONE) dir_d = 1'b0;
                end else begin
                    lvl_d = breathe_lvl + 1'b1;
                    if (breathe_lvl == LVL_TOP_M1) dir_d = 1'b1;
                end
            end else begin
                presc_d = presc + 1'b1;
            end
        end
    end

    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt     <= '0;
            breathe_lvl <= '0;
            dir_down    <= 1'b0;
            presc       <= '0;
        end else begin
            pwm_cnt     <= pwm_cnt + 1'b1;
            breathe_lvl <= lvl_d;
            dir_down    <= dir_d;
            presc       <= presc_d;
        end
    end

    // ---------------- Duty computation ----------------
    logic [PWM_BITS:0]   base_duty;
    logic [PWM_BITS:0]   breathe_duty;
    logic [2*PWM_BITS:0] duty_prod;
    logic [PWM_BITS:0]   cnt_ext;
    logic                on_static, on_breathe;

    always_comb begin
        base_duty    = (PWM_BITS+1)'(gamma_level(sw)) << (PWM_BITS - 4);
        duty_prod    = {{PWM_BITS{1'b0}}, base_duty} * {{(PWM_BITS+1){1'b0}}, breathe_lvl};
        breathe_duty = (PWM_BITS+1)'(duty_prod >> PWM_BITS);
        cnt_ext      = {1'b0, pwm_cnt};
        on_static    = (cnt_ext < base_duty);
        on_breathe   = (cnt_ext < breathe_duty);
    end

    // ---------------- Per-channel button FSMs ----------------
    btn_fsm_e            state_q [NUM_LEDS];
    btn_fsm_e            state_d [NUM_LEDS];
    logic [HOLD_W-1:0]   hold_q  [NUM_LEDS];
    logic [HOLD_W-1:0]   hold_d  [NUM_LEDS];
    logic [2:0]          colour_q[NUM_LEDS];
    logic [2:0]          colour_d[NUM_LEDS];
    logic [NUM_LEDS-1:0] mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        for (int i = 0; i < NUM_LEDS; i++) begin
            state_d[i]  = state_q[i];
            hold_d[i]   = hold_q[i];
            colour_d[i] = colour_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (btn[i]) begin
                        state_d[i] = ST_PRESSED;
                        hold_d[i]  = HOLD_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (btn[i]) begin
                        if (hold_q[i] + HOLD_ONE == HOLD_LONG) begin
                            mode_d[i]  = ~mode_q[i];
                            state_d[i] = ST_LONG;
                            hold_d[i]  = HOLD_LONG;
                        end else begin
                            hold_d[i] = hold_q[i] + HOLD_ONE;
                        end
                    end else begin
                        colour_d[i] = colour_next(colour_q[i]);
                        state_d[i]  = ST_IDLE;
                        hold_d[i]   = '0;
                    end
                end
                ST_LONG: begin
                    if (!btn[i]) begin
                        state_d[i] = ST_IDLE;
                        hold_d[i]  = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    hold_d[i]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            mode_q <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                state_q[i]  <= ST_IDLE;
                hold_q[i]   <= '0;
                colour_q[i] <= 3'd0;
            end
        end else begin
            mode_q <= mode_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                state_q[i]  <= state_d[i];
                hold_q[i]   <= hold_d[i];
                colour_q[i] <= colour_d[i];
            end
        end
    end

    always_comb begin
        fsm_state = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            fsm_state[2*i +: 2] = state_q[i];
        end
    end

    // ---------------- Registered LED outputs ----------------
    logic [NUM_LEDS-1:0] on_vec, r_bit, g_bit, b_bit;
    logic                out_en_q;

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            on_vec[i] = mode_q[i] ? on_breathe : on_static;
            {r_bit[i], g_bit[i], b_bit[i]} = colour_rgb(colour_q[i]);
        end
    end

    // out_en_q holds the colour pins dark on the first edge after reset.
    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            out_en_q <= 1'b0;
            led_r    <= '0;
            led_g    <= '0;
            led_b    <= '0;
            led      <= '0;
        end else begin
            out_en_q <= 1'b1;
            led_r    <= {NUM_LEDS{out_en_q}} & on_vec & (r_bit | btn);
            led_g    <= {NUM_LEDS{out_en_q}} & on_vec & (g_bit | btn);
            led_b    <= {NUM_LEDS{out_en_q}} & on_vec & (b_bit | btn);
            led      <= mode_q;
        end
    end

endmodule
